pcm_play_ctrl: RTL and testbench
================================

// Module: pcm_play_ctrl
// PURPOSE
//  Record/playback sequencer for the PCM audio path. Owns the single-port sample RAM.
//  REC: captures 16-bit microphone samples into the RAM.
//  PLAY: fetches samples once per SLOT_LEN mclk cycles and hands each one to the PWM output stage.
//  PLAY also drives the amplifier shutdown line. Sits between the mic capture front end, the sample RAM and the PWM stage.
// PARAMETERS
//  ADDR_W    12  sample RAM address width; capacity 2**ADDR_W samples
//  DATA_W    16  PCM sample width
//  SLOT_LEN  16  mclk cycles per played sample, matching the PWM serializer frame; must be >= 4
// PORTS
//  mclk        in   1         clock; all logic on posedge mclk
//  reset       in   1         reset, synchronous, active-high
//  cmd_rec     in   1         1-cycle pulse: start recording at address 0
//  cmd_play    in   1         1-cycle pulse: start playback at address 0
//  cmd_stop    in   1         1-cycle pulse: abort the current operation
//  mic_valid   in   1         mic_data valid strobe, at most 1 per cycle
//  mic_data    in   DATA_W    captured PCM sample
//  ram_addr    out  ADDR_W    RAM address (registered)
//  ram_we      out  1         RAM write enable (registered)
//  ram_wdata   out  DATA_W    RAM write data (registered)
//  ram_rdata   in   DATA_W    RAM read data, valid 1 cycle after ram_addr
//  pwm_sample  out  DATA_W    sample currently presented to the PWM stage
//  pwm_load    out  1         1-cycle pulse: pwm_sample updated
//  amp_sd      out  1         amplifier enable: 1 only in PLAY
//  busy        out  1         state != IDLE
//  rec_len     out  ADDR_W+1  number of valid recorded samples
//  rec_full    out  1         last recording stopped because the RAM was full (sticky until next cmd_rec)
//  play_done   out  1         1-cycle pulse: playback reached the end of the buffer
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (rec_len=0, rec_full=0, amp_sd=0, pwm_sample=0).
//   Reset asserted mid-operation aborts immediately; no RAM write is issued in that cycle.
//  FSM states: IDLE, REC, PLAY.
//  cmd_stop has priority over every other input in every state.
//   Next state: IDLE. ram_we, pwm_sample and amp_sd are 0 in the following cycle.
//  IDLE:
//   cmd_rec -> REC; wr_ptr=0; rec_full=0.
//   cmd_play with rec_len != 0 -> PLAY; rd_ptr=0; slot_cnt=0.
//   cmd_play with rec_len == 0 is ignored.
//   cmd_rec and cmd_play in the same cycle: cmd_rec wins.
//  REC, each mic_valid:
//   ram_we=1, ram_addr=wr_ptr, ram_wdata=mic_data (1-cycle write latency); wr_ptr++.
//   Write to address 2**ADDR_W-1: rec_len=2**ADDR_W, rec_full=1, next state IDLE.
//   cmd_stop: rec_len=wr_ptr (the count of writes already issued); a mic_valid in the same cycle is dropped.
//   cmd_play and cmd_rec are ignored while in REC.
//  PLAY: slot_cnt counts 0..SLOT_LEN-1, then wraps.
//   slot cycle 0: ram_addr=rd_ptr, ram_we=0.
//   End of slot cycle 1: capture ram_rdata.
//   Slot cycle 2: pwm_sample=captured value, pwm_load=1 for exactly 1 cycle.
//   First pwm_load: 2 cycles after the PLAY entry cycle; then one every SLOT_LEN cycles.
//   At slot_cnt==SLOT_LEN-1: rd_ptr++.
//   If rd_ptr == rec_len-1 (last sample) at slot_cnt==SLOT_LEN-1: play_done=1 that cycle.
//    Then IDLE, pwm_sample=0, amp_sd=0 (subject to CONFIGURATION).
//   mic_valid is ignored in PLAY. cmd_rec and cmd_play are ignored in PLAY.
//  amp_sd=1 in every PLAY cycle; 0 in all other states.
//  Pointer arithmetic is unsigned ADDR_W bits. rec_len is ADDR_W+1 bits so that the full count is representable.
// CONFIGURATION
//  PCM_PLAY_LOOP_EN defined:
//   At the end of the buffer, rd_ptr wraps to 0 and PLAY continues until cmd_stop.
//   play_done still pulses at every wrap. The sample cadence has no gap across the wrap.
//  PCM_PLAY_LOOP_EN not defined:
//   At the end of the buffer, go to IDLE as described in BEHAVIOUR.
// STRUCTURE
//  Package pcm_pkg:
//   state enum pcm_state_t {IDLE, REC, PLAY}.
//   DATA_W default.
//   SLOT_LEN default.
//   Slot-cycle constants SLOT_RD=0, SLOT_CAP=1, SLOT_LOAD=2.
//  Sub-module pcm_slot_timer: SLOT_LEN counter with clear and enable.
//   Outputs slot_cnt and a last-cycle flag.
//   Instantiated once; cleared on PLAY entry.
//  Arbitration: RAM port driven by REC writes or PLAY reads only, selected by state.
//   REC and PLAY are mutually exclusive, so the two never contend.
// TESTING
//  Record: reset; cmd_rec; 5 mic_valid with data 0x0001..0x0005; cmd_stop.
//   -> 5 RAM writes to addresses 0..4; rec_len=5; busy falls 1 cycle after cmd_stop.
//  Full: ADDR_W=4; 20 mic_valid strobes.
//   -> exactly 16 writes; rec_len=16; rec_full=1; state IDLE; last 4 strobes produce no write.
//  Play: rec_len=3 with RAM = 0x1111, 0x2222, 0x3333; cmd_play; SLOT_LEN=16.
//   -> pwm_load at entry+2, +18, +34 with those values; play_done at entry+47; then pwm_sample=0, amp_sd=0.
//  Loop build: same stimulus as Play, compiled with PCM_PLAY_LOOP_EN.
//   -> 4th pwm_load at entry+50 carries 0x1111; play_done at each wrap; cmd_stop -> IDLE next cycle.
//  Conflicts: cmd_rec and cmd_play in the same cycle -> REC.
//   cmd_play while rec_len=0 -> stays IDLE.
//   cmd_stop in the same cycle as mic_valid -> no write; rec_len unchanged by that sample.
//  Reset mid-PLAY at slot cycle 1: next cycle all outputs 0 and state IDLE.
//   pwm_load does not pulse.
//   rec_len is reset to 0.

Source files
------------

// File: rtl/pcm_play_ctrl_pkg.sv
// Shared types and constants for the PCM record/playback sequencer.
// Exports pcm_state_t, width/length defaults and the slot-cycle indices.
package pcm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REC,
    PLAY
  } pcm_state_t;

  localparam int ADDR_W_DEF   = 12;
  localparam int DATA_W_DEF   = 16;
  localparam int SLOT_LEN_DEF = 16;

  localparam int SLOT_RD   = 0;
  localparam int SLOT_CAP  = 1;
  localparam int SLOT_LOAD = 2;

endpackage

// File: rtl/pcm_play_ctrl_if.sv
// Single-port sample RAM bus between the sequencer and the RAM.
// Signals: addr, we, wdata (master->RAM) and rdata (RAM->master, 1-cycle latency).
interface pcm_ram_if
  import pcm_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (
    output addr,
    output we,
    output wdata,
    input  rdata
  );

  modport slave (
    input  addr,
    input  we,
    input  wdata,
    output rdata
  );

endinterface

// File: rtl/pcm_play_ctrl_slot_timer.sv
// Free-running 0..SLOT_LEN-1 slot counter with clear and enable.
// Ports: mclk, reset, clr, en in; slot_cnt and last (cnt == SLOT_LEN-1) out.
module pcm_slot_timer
  import pcm_pkg::*;
#(
  parameter int SLOT_LEN = SLOT_LEN_DEF,
  parameter int CNT_W    = $clog2(SLOT_LEN)
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] slot_cnt,
  output logic             last
);

  assign last = (slot_cnt == CNT_W'(SLOT_LEN - 1));

  always_ff @(posedge mclk) begin
    if (reset || clr) begin
      slot_cnt <= '0;
    end else if (en) begin
      slot_cnt <= last ? '0 : slot_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pcm_play_ctrl.sv
// Record/playback sequencer: owns the sample RAM, feeds the PWM stage, drives amp_sd.
// Ports: mclk/reset, cmd_rec/play/stop, mic_valid/data, ram (pcm_ram_if.master),
//   pwm_sample/load, amp_sd, busy, rec_len, rec_full, play_done.
// Build option: PCM_PLAY_LOOP_EN makes playback wrap to address 0 until cmd_stop.
module pcm_play_ctrl
  import pcm_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int SLOT_LEN = SLOT_LEN_DEF
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic              cmd_rec,
  input  logic              cmd_play,
  input  logic              cmd_stop,
  input  logic              mic_valid,
  input  logic [DATA_W-1:0] mic_data,
  pcm_ram_if.master         ram,
  output logic [DATA_W-1:0] pwm_sample,
  output logic              pwm_load,
  output logic              amp_sd,
  output logic              busy,
  output logic [ADDR_W:0]   rec_len,
  output logic              rec_full,
  output logic              play_done
);

`ifdef PCM_PLAY_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  localparam int CNT_W = $clog2(SLOT_LEN);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  pcm_state_t state, state_nxt;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] rd_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  slot_cnt;
  logic              slot_last;

  logic rec_go;
  logic play_go;
  logic wr_fire;
  logic wr_last;
  logic rd_last;
  logic buf_end;

  assign ram.addr  = addr_q;
  assign ram.we    = we_q;
  assign ram.wdata = wdata_q;

  assign busy   = (state != IDLE);
  assign amp_sd = (state == PLAY);

  // cmd_rec beats cmd_play; cmd_stop beats both.
  assign rec_go  = (state == IDLE) && !cmd_stop && cmd_rec;
  assign play_go = (state == IDLE) && !cmd_stop && !cmd_rec
                && cmd_play && (rec_len != '0);

  assign wr_fire = (state == REC) && mic_valid && !cmd_stop;
  assign wr_last = wr_fire && (wr_ptr == LAST_ADDR);

  assign rd_last = ({1'b0, rd_ptr} == rec_len - 1'b1);
  assign buf_end = (state == PLAY) && slot_last && rd_last;
  assign play_done = buf_end;

  // Address of the next slot's sample; wraps at the buffer end.
  always_comb begin
    rd_nxt = rd_ptr;
    if (slot_last) begin
      rd_nxt = rd_last ? '0 : rd_ptr + 1'b1;
    end
  end

  pcm_slot_timer #(
    .SLOT_LEN (SLOT_LEN),
    .CNT_W    (CNT_W)
  ) u_slot (
    .mclk     (mclk),
    .reset    (reset),
    .clr      (play_go),
    .en       (state == PLAY),
    .slot_cnt (slot_cnt),
    .last     (slot_last)
  );

  always_ff @(posedge mclk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (cmd_stop) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            rec_go:  state_nxt = REC;
            play_go: state_nxt = PLAY;
            default: ;
          endcase
        end
        REC: begin
          if (wr_last) state_nxt = IDLE;
        end
        PLAY: begin
          if (buf_end && !LOOP) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      pwm_sample <= '0;
      pwm_load   <= 1'b0;
      rec_len    <= '0;
      rec_full   <= 1'b0;
    end else begin
      we_q     <= 1'b0;
      pwm_load <= 1'b0;
      if (cmd_stop) begin
        pwm_sample <= '0;
        // Only writes already issued count; a same-cycle strobe is dropped.
        if (state == REC) rec_len <= {1'b0, wr_ptr};
      end else begin
        unique case (state)
          IDLE: begin
            if (rec_go) begin
              wr_ptr   <= '0;
              rec_full <= 1'b0;
            end else if (play_go) begin
              rd_ptr <= '0;
              addr_q <= '0;
            end
          end
          REC: begin
            if (wr_fire) begin
              we_q    <= 1'b1;
              addr_q  <= wr_ptr;
              wdata_q <= mic_data;
              wr_ptr  <= wr_ptr + 1'b1;
              if (wr_ptr == LAST_ADDR) begin
                rec_len  <= {1'b1, {ADDR_W{1'b0}}};
                rec_full <= 1'b1;
              end
            end
          end
          PLAY: begin
            // rdata for the address set at slot cycle 0 is valid now.
            if (slot_cnt == CNT_W'(SLOT_CAP)) begin
              pwm_sample <= ram.rdata;
              pwm_load   <= 1'b1;
            end
            // Present the next address so it lands in slot cycle 0.
            if (slot_last) begin
              rd_ptr <= rd_nxt;
              addr_q <= rd_nxt;
            end
            if (buf_end && !LOOP) pwm_sample <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pcm_play_ctrl.sv
// Self-checking bench for pcm_play_ctrl (ADDR_W=4, SLOT_LEN=16) with a RAM model.
// Define PCM_PLAY_LOOP_EN for both bench and RTL to exercise the looping build.
module tb_pcm_play_ctrl;

  localparam int AW = 4;
  localparam int DW = 16;
  localparam int SL = 16;

  logic          mclk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_rec = 1'b0;
  logic          cmd_play = 1'b0;
  logic          cmd_stop = 1'b0;
  logic          mic_valid = 1'b0;
  logic [DW-1:0] mic_data = '0;
  logic [DW-1:0] pwm_sample;
  logic          pwm_load;
  logic          amp_sd;
  logic          busy;
  logic [AW:0]   rec_len;
  logic          rec_full;
  logic          play_done;

  always #5 mclk = ~mclk;

  pcm_ram_if #(.ADDR_W(AW), .DATA_W(DW)) ram ();

  pcm_play_ctrl #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .SLOT_LEN (SL)
  ) dut (
    .mclk       (mclk),
    .reset      (reset),
    .cmd_rec    (cmd_rec),
    .cmd_play   (cmd_play),
    .cmd_stop   (cmd_stop),
    .mic_valid  (mic_valid),
    .mic_data   (mic_data),
    .ram        (ram),
    .pwm_sample (pwm_sample),
    .pwm_load   (pwm_load),
    .amp_sd     (amp_sd),
    .busy       (busy),
    .rec_len    (rec_len),
    .rec_full   (rec_full),
    .play_done  (play_done)
  );

  logic [DW-1:0] mem [16];

  always @(posedge mclk) begin
    if (ram.we) mem[ram.addr] <= ram.wdata;
    ram.rdata <= mem[ram.addr];
  end

  int cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct { int addr; int data; } wr_t;
  typedef struct { int cyc; int val; } ld_t;

  wr_t wq [$];
  ld_t lq [$];
  int  dq [$];
  wr_t w_pop;
  ld_t l_pop;
  int  d_pop;

  always @(negedge mclk) begin
    if (!reset) begin
      if (ram.we) begin
        if (wq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL wr_unexp: addr %0h data %0h, expected no write",
                   ram.addr, ram.wdata);
        end else begin
          w_pop = wq.pop_front();
          chk("wr_addr", int'(ram.addr), w_pop.addr);
          chk("wr_data", int'(ram.wdata), w_pop.data);
        end
      end
      if (pwm_load) begin
        if (lq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL load_unexp: cyc %0d val %0h, expected no load",
                   cyc, pwm_sample);
        end else begin
          l_pop = lq.pop_front();
          chk("load_cyc", cyc, l_pop.cyc);
          chk("load_val", int'(pwm_sample), l_pop.val);
        end
      end
      if (play_done) begin
        if (dq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL done_unexp: cyc %0d, expected no play_done", cyc);
        end else begin
          d_pop = dq.pop_front();
          chk("done_cyc", cyc, d_pop);
        end
      end
    end
  end

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic wait_cyc(int n);
    while (cyc < n) tick();
  endtask

  task automatic push_wr(int a, int d);
    wr_t w;
    w.addr = a;
    w.data = d;
    wq.push_back(w);
  endtask

  task automatic push_ld(int c, int v);
    ld_t l;
    l.cyc = c;
    l.val = v;
    lq.push_back(l);
  endtask

  typedef struct {
    logic        rec;
    logic        play;
    logic        stop;
    logic        mv;
    logic [15:0] data;
    logic        push;
    int          waddr;
    logic        busy;
    int          len;
    logic        full;
  } vec_t;

  // Expected outputs are observed in the cycle the inputs are applied,
  // so they reflect the effect of the previous rows.
  vec_t tbl [16];

  initial begin
    #100000;
    $display("FAIL watchdog: sim time exceeded, expected $finish");
    $fatal(1);
  end

  initial begin
    int e;
    tbl = '{
      '{0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0},
      '{0, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 0},
      '{0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0},
      '{1, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 0},
      '{0, 0, 0, 1, 16'h0001, 1, 0, 1, 0, 0},
      '{0, 0, 0, 1, 16'h0002, 1, 1, 1, 0, 0},
      '{0, 0, 0, 1, 16'h0003, 1, 2, 1, 0, 0},
      '{0, 0, 0, 1, 16'h0004, 1, 3, 1, 0, 0},
      '{0, 0, 0, 1, 16'h0005, 1, 4, 1, 0, 0},
      '{0, 0, 1, 0, 16'h0000, 0, 0, 1, 0, 0},
      '{0, 0, 0, 0, 16'h0000, 0, 0, 0, 5, 0},
      '{1, 1, 0, 0, 16'h0000, 0, 0, 0, 5, 0},
      '{0, 0, 0, 1, 16'h000A, 1, 0, 1, 5, 0},
      '{1, 1, 0, 1, 16'h000B, 1, 1, 1, 5, 0},
      '{0, 0, 1, 1, 16'h00CC, 0, 0, 1, 5, 0},
      '{0, 0, 0, 0, 16'h0000, 0, 0, 0, 2, 0}
    };

    repeat (3) tick();
    reset = 1'b0;
    @(negedge mclk);
    chk("rst_busy", busy, 0);
    chk("rst_amp", amp_sd, 0);
    chk("rst_len", int'(rec_len), 0);
    chk("rst_full", rec_full, 0);
    chk("rst_pwm", int'(pwm_sample), 0);
    chk("rst_load", pwm_load, 0);
    chk("rst_we", ram.we, 0);

    for (int i = 0; i < 16; i++) begin
      tick();
      cmd_rec   = tbl[i].rec;
      cmd_play  = tbl[i].play;
      cmd_stop  = tbl[i].stop;
      mic_valid = tbl[i].mv;
      mic_data  = tbl[i].data;
      if (tbl[i].push) push_wr(tbl[i].waddr, int'(tbl[i].data));
      @(negedge mclk);
      chk("vec_busy", busy, tbl[i].busy);
      chk("vec_len", int'(rec_len), tbl[i].len);
      chk("vec_full", rec_full, tbl[i].full);
      chk("vec_amp", amp_sd, 0);
    end
    tick();
    cmd_rec = 0; cmd_play = 0; cmd_stop = 0; mic_valid = 0;

    // Overflow: 20 strobes into a 16-entry RAM.
    tick(); cmd_rec = 1'b1;
    tick(); cmd_rec = 1'b0;
    for (int i = 0; i < 20; i++) begin
      mic_valid = 1'b1;
      mic_data  = DW'(16'h0100 + i);
      if (i < 16) push_wr(i, 16'h0100 + i);
      tick();
    end
    mic_valid = 1'b0;
    tick();
    @(negedge mclk);
    chk("full_len", int'(rec_len), 16);
    chk("full_flag", rec_full, 1);
    chk("full_busy", busy, 0);
    chk("full_wq", wq.size(), 0);

    // Three-sample recording for playback.
    tick(); cmd_rec = 1'b1;
    tick(); cmd_rec = 1'b0;
    mic_valid = 1'b1; mic_data = 16'h1111; push_wr(0, 16'h1111);
    tick(); mic_data = 16'h2222; push_wr(1, 16'h2222);
    tick(); mic_data = 16'h3333; push_wr(2, 16'h3333);
    tick(); mic_valid = 1'b0; cmd_stop = 1'b1;
    tick(); cmd_stop = 1'b0;
    @(negedge mclk);
    chk("rec3_len", int'(rec_len), 3);
    chk("rec3_full", rec_full, 0);
    chk("rec3_busy", busy, 0);

    // Playback.
    tick(); cmd_play = 1'b1;
    e = cyc + 1;
    push_ld(e + 2, 16'h1111);
    push_ld(e + 18, 16'h2222);
    push_ld(e + 34, 16'h3333);
    dq.push_back(e + 47);
`ifdef PCM_PLAY_LOOP_EN
    push_ld(e + 50, 16'h1111);
`endif
    tick(); cmd_play = 1'b0;
    wait_cyc(e + 10);
    @(negedge mclk);
    chk("play_amp", amp_sd, 1);
    chk("play_busy", busy, 1);
`ifdef PCM_PLAY_LOOP_EN
    wait_cyc(e + 52);
    cmd_stop = 1'b1;
    tick(); cmd_stop = 1'b0;
    @(negedge mclk);
    chk("stop_busy", busy, 0);
    chk("stop_amp", amp_sd, 0);
    chk("stop_pwm", int'(pwm_sample), 0);
`else
    wait_cyc(e + 48);
    @(negedge mclk);
    chk("end_busy", busy, 0);
    chk("end_amp", amp_sd, 0);
    chk("end_pwm", int'(pwm_sample), 0);
    wait_cyc(e + 60);
`endif
    chk("play_lq", lq.size(), 0);
    chk("play_dq", dq.size(), 0);

    // Reset during slot cycle 1 of a new playback.
    tick(); cmd_play = 1'b1;
    e = cyc + 1;
    tick(); cmd_play = 1'b0;
    wait_cyc(e + 1);
    reset = 1'b1;
    tick(); reset = 1'b0;
    @(negedge mclk);
    chk("mid_busy", busy, 0);
    chk("mid_amp", amp_sd, 0);
    chk("mid_load", pwm_load, 0);
    chk("mid_pwm", int'(pwm_sample), 0);
    chk("mid_len", int'(rec_len), 0);
    chk("mid_we", ram.we, 0);
    wait_cyc(cyc + 20);
    chk("mid_idle", busy, 0);

    chk("end_wq", wq.size(), 0);
    chk("end_lq", lq.size(), 0);
    chk("end_dq", dq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
